// File: rtl/shrv_pkg.sv
// rtl/shrv_pkg.sv - shared widths, constants and the fetch buffer entry type
package shrv_pkg;

  localparam int          XLEN    = 32;
  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - two-entry skid FIFO of fetched (pc, inst) pairs
module fetch_skid_fifo
  import shrv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         valid_o,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         head_q, head_d;
  logic         tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push_i) tail_d = ~tail_q;
      if (pop_i)  head_d = ~head_q;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Data stays put on flush; only the pointers and count are cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i && !flush_i) mem_q[tail_q] <= push_entry_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, ROM request tracking and redirect handling for fetch
module fetch_unit
  import shrv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic [XLEN-1:0] IMEM_A,
  input  logic [XLEN-1:0] IMEM_RD,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            INST_VALID,
  input  logic            INST_READY,
  output logic [XLEN-1:0] INST,
  output logic [XLEN-1:0] INST_PC
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            req_valid_q, req_valid_d;

  logic            pop, push, issue;
  logic [1:0]      fifo_count;
  logic [2:0]      occupancy;
  fetch_entry_t    head, push_entry;

  assign pop       = INST_VALID & INST_READY;
  // Entries that will be held after this edge, counting the ROM read in flight.
  assign occupancy = {1'b0, fifo_count} + {2'b00, req_valid_q} - {2'b00, pop};
  assign issue     = !REDIRECT_VALID && (occupancy < 3'd2);
  assign push      = req_valid_q && !REDIRECT_VALID;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = 1'b0;
    if (REDIRECT_VALID) begin
      fetch_pc_d = REDIRECT_PC & ~{{(XLEN-2){1'b0}}, 2'b11};
    end else if (issue) begin
      req_valid_d = 1'b1;
      req_pc_d    = fetch_pc_q;
      fetch_pc_d  = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  // The ROM samples this on the issue edge, so its data lines up with req_pc_q.
  assign IMEM_A = fetch_pc_q;

  assign push_entry.pc   = req_pc_q;
  assign push_entry.inst = IMEM_RD;

  fetch_skid_fifo u_skid (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (REDIRECT_VALID),
    .valid_o      (INST_VALID),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  assign INST    = head.inst;
  assign INST_PC = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a behavioural ROM
module tb_fetch_unit;

  logic        clk;
  logic        rst_n, rst2_n;
  logic [31:0] imem_a, imem_rd, imem_a2, imem_rd2;
  logic        redir_v, redir_v2;
  logic [31:0] redir_pc, redir_pc2;
  logic        inst_valid, inst_valid2;
  logic        inst_ready, inst_ready2;
  logic [31:0] inst, inst_pc, inst2, inst_pc2;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RST_N(rst_n), .IMEM_A(imem_a), .IMEM_RD(imem_rd),
    .REDIRECT_VALID(redir_v), .REDIRECT_PC(redir_pc),
    .INST_VALID(inst_valid), .INST_READY(inst_ready),
    .INST(inst), .INST_PC(inst_pc)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .CLK(clk), .RST_N(rst2_n), .IMEM_A(imem_a2), .IMEM_RD(imem_rd2),
    .REDIRECT_VALID(redir_v2), .REDIRECT_PC(redir_pc2),
    .INST_VALID(inst_valid2), .INST_READY(inst_ready2),
    .INST(inst2), .INST_PC(inst_pc2)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h00:  rom_word = 32'h00100f93;
      32'h04:  rom_word = 32'h0000408b;
      32'h08:  rom_word = 32'h01ffcfb3;
      32'h0C:  rom_word = 32'h0000410b;
      32'h10:  rom_word = 32'h00000013;
      32'h14:  rom_word = 32'h00000013;
      32'h18:  rom_word = 32'h00000013;
      32'h1C:  rom_word = 32'h000f8b13;
      32'h20:  rom_word = 32'h00100a93;
      32'h24:  rom_word = 32'h00208113;
      32'h28:  rom_word = 32'h00310193;
      default: rom_word = 32'h00000000;
    endcase
  endfunction

  always @(posedge clk) begin
    imem_rd  <= rom_word(imem_a);
    imem_rd2 <= rom_word(imem_a2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] seq_pc   [4];
  logic [31:0] seq_inst [4];

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst_n      = 1'b0;
    redir_v    = 1'b0;
    redir_pc   = 32'h0;
    inst_ready = ready;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; redir_v = 1'b0; redir_pc = 32'h0; inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    checks++;
    if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 00000000", inst); end
    checks++;
    if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", inst_pc); end
    checks++;
    if (imem_a !== 32'h0) begin errors++; $display("FAIL reset_imem_a: got %h want 00000000", imem_a); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL first_edge_valid: got %b want 0", inst_valid); end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_edge1: got valid %b want 0", inst_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== seq_pc[i] || inst !== seq_inst[i]) begin
        errors++;
        $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, seq_pc[i], seq_inst[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h00100f93) begin
      errors++; $display("FAIL bp_first: got v=%b pc=%h inst=%h want v=1 pc=0 inst=00100f93", inst_valid, inst_pc, inst);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h00100f93) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h inst=%h want v=1 pc=0 inst=00100f93", i, inst_valid, inst_pc, inst);
      end
    end
    checks++;
    if (imem_a !== 32'h8) begin errors++; $display("FAIL bp_imem_a: got %h want 00000008", imem_a); end
    inst_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== seq_pc[i] || inst !== seq_inst[i]) begin
        errors++;
        $display("FAIL bp_release[%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, seq_pc[i], seq_inst[i]);
      end
    end
  endtask

  task automatic test_redirect_flush;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    redir_v = 1'b1; redir_pc = 32'h20;
    @(negedge clk);
    redir_v = 1'b0; inst_ready = 1'b1;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_r0: got valid %b want 0", inst_valid); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_r1: got valid %b want 0", inst_valid); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== 32'h00100a93) begin
      errors++; $display("FAIL flush_target: got v=%b pc=%h inst=%h want v=1 pc=20 inst=00100a93", inst_valid, inst_pc, inst);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h24 || inst !== 32'h00208113) begin
      errors++; $display("FAIL flush_next: got v=%b pc=%h inst=%h want v=1 pc=24 inst=00208113", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_redirect_align;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    redir_v = 1'b1; redir_pc = 32'h1E;
    @(negedge clk);
    redir_v = 1'b0;
    checks++;
    if (imem_a !== 32'h1C) begin errors++; $display("FAIL align_imem_a: got %h want 0000001c", imem_a); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL align_gap: got valid %b want 0", inst_valid); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h1C || inst !== 32'h000f8b13) begin
      errors++; $display("FAIL align_target: got v=%b pc=%h inst=%h want v=1 pc=1c inst=000f8b13", inst_valid, inst_pc, inst);
    end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== 32'h00100a93) begin
      errors++; $display("FAIL align_next: got v=%b pc=%h inst=%h want v=1 pc=20 inst=00100a93", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_redirect_handshake;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== 32'h0000408b) begin
      errors++; $display("FAIL hs_head: got v=%b pc=%h inst=%h want v=1 pc=4 inst=0000408b", inst_valid, inst_pc, inst);
    end
    redir_v = 1'b1; redir_pc = 32'h20;
    @(negedge clk);
    redir_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (inst_valid !== 1'b0) begin
        errors++; $display("FAIL hs_gap[%0d]: got v=%b pc=%h want v=0", i, inst_valid, inst_pc);
      end
      @(negedge clk);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== 32'h00100a93) begin
      errors++; $display("FAIL hs_target: got v=%b pc=%h inst=%h want v=1 pc=20 inst=00100a93", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_back_to_back;
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    redir_v = 1'b1; redir_pc = 32'h1C;
    @(negedge clk);
    redir_pc = 32'h20;
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_first: got valid %b want 0", inst_valid); end
    @(negedge clk);
    redir_v = 1'b0;
    checks++;
    if (imem_a !== 32'h20) begin errors++; $display("FAIL b2b_imem_a: got %h want 00000020", imem_a); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got valid %b want 0", inst_valid); end
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== 32'h00100a93) begin
      errors++; $display("FAIL b2b_target: got v=%b pc=%h inst=%h want v=1 pc=20 inst=00100a93", inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap_and_async;
    logic [31:0] wpc [3];
    logic [31:0] winst [3];
    wpc[0] = 32'hFFFF_FFFC; winst[0] = 32'h00000000;
    wpc[1] = 32'h0000_0000; winst[1] = 32'h00100f93;
    wpc[2] = 32'h0000_0004; winst[2] = 32'h0000408b;
    checks++;
    if (imem_a2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset_a: got %h want fffffffc", imem_a2); end
    for (int pass = 0; pass < 2; pass++) begin
      rst2_n = 1'b1;
      @(negedge clk);
      checks++;
      if (inst_valid2 !== 1'b0) begin errors++; $display("FAIL wrap_edge1[%0d]: got valid %b want 0", pass, inst_valid2); end
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checks++;
        if (inst_valid2 !== 1'b1 || inst_pc2 !== wpc[i] || inst2 !== winst[i]) begin
          errors++;
          $display("FAIL wrap[%0d][%0d]: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                   pass, i, inst_valid2, inst_pc2, inst2, wpc[i], winst[i]);
        end
      end
      #2 rst2_n = 1'b0;
      #1;
      checks++;
      if (inst_valid2 !== 1'b0) begin errors++; $display("FAIL async_valid[%0d]: got %b want 0", pass, inst_valid2); end
      checks++;
      if (imem_a2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL async_imem_a[%0d]: got %h want fffffffc", pass, imem_a2); end
      @(negedge clk);
    end
  endtask

  initial begin
    seq_pc[0] = 32'h0; seq_inst[0] = 32'h00100f93;
    seq_pc[1] = 32'h4; seq_inst[1] = 32'h0000408b;
    seq_pc[2] = 32'h8; seq_inst[2] = 32'h01ffcfb3;
    seq_pc[3] = 32'hC; seq_inst[3] = 32'h0000410b;
    rst2_n = 1'b0; redir_v2 = 1'b0; redir_pc2 = 32'h0; inst_ready2 = 1'b1;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_align();
    test_redirect_handshake();
    test_back_to_back();
    test_wrap_and_async();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
